// File: rtl/led_seq_ctrl.sv
// LED sequencing controller: steady on/off, continuous blink and finite-burst blink
// with a shared prescaled timebase and a one-command handshake.
module led_seq_ctrl #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [2:0] cmd_rate,
    input  logic [7:0] cmd_count,
    output logic       LED,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StSteady,
        StPhOn,
        StPhOff
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [9:0]    phase;
    logic [7:0]    remaining;
    logic [1:0]    mode;
    logic [2:0]    rate;

    logic       tick;
    logic       accept;
    logic       in_phase;
    logic       phase_end;
    logic [9:0] hp_last;

    assign cmd_ready = ~busy;
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (presc == PRESC_LAST);
    assign in_phase  = (state == StPhOn) || (state == StPhOff);
    // HP-1 as a mask of the low (rate+3) bits; rate 7 gives all ten bits set.
    assign hp_last   = ~(10'h3FF << ({1'b0, rate} + 4'd3));
    assign phase_end = tick && in_phase && (phase == hp_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            presc     <= '0;
            phase     <= '0;
            remaining <= '0;
            mode      <= MODE_OFF;
            rate      <= '0;
            LED       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done  <= 1'b0;
            presc <= tick ? '0 : presc + PW'(1);

            if (accept) begin
                presc     <= '0;
                phase     <= '0;
                mode      <= cmd_mode;
                rate      <= cmd_rate;
                remaining <= (cmd_mode == MODE_BURST) ? cmd_count : 8'd0;
                case (cmd_mode)
                    MODE_OFF: begin
                        state <= StIdle;
                        LED   <= 1'b0;
                        busy  <= 1'b0;
                    end
                    MODE_ON: begin
                        state <= StSteady;
                        LED   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    MODE_BLINK: begin
                        state <= StPhOn;
                        LED   <= 1'b1;
                        busy  <= 1'b0;
                    end
                    MODE_BURST: begin
                        if (cmd_count == 8'd0) begin
                            state <= StIdle;
                            LED   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= StPhOn;
                            LED   <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                endcase
            end else if (tick && in_phase) begin
                if (phase_end) begin
                    phase <= '0;
                    if (state == StPhOn) begin
                        state <= StPhOff;
                        LED   <= 1'b0;
                    end else if (mode != MODE_BURST) begin
                        state <= StPhOn;
                        LED   <= 1'b1;
                    end else if (remaining <= 8'd1) begin
                        // Last blink: guard with <= so the count can never wrap.
                        state     <= StIdle;
                        remaining <= 8'd0;
                        LED       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state     <= StPhOn;
                        remaining <= remaining - 8'd1;
                        LED       <= 1'b1;
                    end
                end else begin
                    phase <= phase + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus random commands,
// compared each cycle against a timeline model derived from the last accepted command.
module tb_led_seq_ctrl;

    localparam int unsigned PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_rate;
    logic [7:0] cmd_count;
    logic       led;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: outputs are a pure function of the last accepted command and time since it.
    int m_ta    = -1;
    int m_mode  = 0;
    int m_rate  = 0;
    int m_count = 0;

    led_seq_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_rate  (cmd_rate),
        .cmd_count (cmd_count),
        .LED       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_out(input int t, output logic el, output logic eb, output logic ed);
        int e;
        int p;
        int k;
        e  = t - m_ta - 1;
        p  = PRESCALE * (1 << (m_rate + 3));
        k  = e / p;
        el = 1'b0;
        eb = 1'b0;
        ed = 1'b0;
        case (m_mode)
            1: el = 1'b1;
            2: el = (k % 2 == 0);
            3: begin
                if (m_count == 0) begin
                    ed = (e == 0);
                end else begin
                    if (k < 2 * m_count) begin
                        eb = 1'b1;
                        el = (k % 2 == 0);
                    end
                    ed = (e == 2 * m_count * p);
                end
            end
            default: ;
        endcase
    endtask

    // One cycle: check outputs of the current cycle, then drive this cycle's inputs.
    task automatic step(input logic v, input logic [1:0] md, input logic [2:0] rt,
                        input logic [7:0] ct, input logic r);
        logic el, eb, ed;
        model_out(cyc, el, eb, ed);
        check_eq("led", led, el);
        check_eq("busy", busy, eb);
        check_eq("done", done, ed);
        check_eq("cmd_ready", cmd_ready, ~eb);
        rst       = r;
        cmd_valid = v;
        cmd_mode  = md;
        cmd_rate  = rt;
        cmd_count = ct;
        if (r) begin
            m_ta   = cyc;
            m_mode = 0;
        end else if (v && !eb) begin
            m_ta    = cyc;
            m_mode  = int'(md);
            m_rate  = int'(rt);
            m_count = int'(ct);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 3'd0, 8'd0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_rate  = 3'd0;
        cmd_count = 8'd0;
        @(posedge clk);
        #1;
        step(1'b0, 2'd0, 3'd0, 8'd0, 1'b1);
        idle(3);

        // Steady on, then off ten cycles later.
        step(1'b1, 2'd1, 3'd0, 8'd0, 1'b0);
        idle(9);
        step(1'b1, 2'd0, 3'd0, 8'd0, 1'b0);
        idle(5);

        // Burst of three at rate 0.
        step(1'b1, 2'd3, 3'd0, 8'd3, 1'b0);
        idle(205);

        // Back-pressure: OFF held through a burst of two.
        step(1'b1, 2'd3, 3'd0, 8'd2, 1'b0);
        for (int i = 0; i < 140; i++) step(1'b1, 2'd0, 3'd0, 8'd0, 1'b0);
        idle(5);

        // Zero-count burst.
        step(1'b1, 2'd3, 3'd2, 8'd0, 1'b0);
        idle(10);

        // Re-command a running blink, then reset mid-burst.
        step(1'b1, 2'd2, 3'd1, 8'd0, 1'b0);
        idle(19);
        step(1'b1, 2'd2, 3'd0, 8'd0, 1'b0);
        idle(100);
        step(1'b1, 2'd3, 3'd0, 8'd3, 1'b0);
        idle(50);
        step(1'b1, 2'd0, 3'd0, 8'd0, 1'b1);
        idle(300);

        for (int i = 0; i < 15000; i++) begin
            step(($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 2)), 8'($urandom_range(0, 4)),
                 ($urandom_range(0, 1499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
